// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the seven-segment scan driver.
package seg7_pkg;

    // Blank segment pattern on the active-low segment bus.
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Hex font, active-high {g,f,e,d,c,b,a}, indexed by nibble value.
    localparam logic [6:0] HEX_FONT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Counter width for a counter that takes n distinct values; never below 1.
    function automatic int unsigned ctrWidth(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Snapshot arming: the first clock after reset always loads a snapshot.
    typedef enum logic {
        ST_UNPRIMED = 1'b0,
        ST_RUNNING  = 1'b1
    } scanState_t;

endpackage

// File: rtl/seg7_scan_driver_hex_decoder.sv
// Combinational nibble to seven-segment font lookup (active-high).
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segments
);

    // Straight table lookup into the shared font.
    always_comb begin
        segments = HEX_FONT[nibble];
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with per-frame input snapshot,
// per-digit decimal point and blanking, leading-zero suppression and dead time.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned DIGITS       = 8,
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned BLANK_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [4*DIGITS-1:0]   iData,
    input  logic [DIGITS-1:0]     iDp,
    input  logic [DIGITS-1:0]     iBlank,
    input  logic                  iLzs,
    output logic [6:0]            oSeg,
    output logic                  oDp,
    output logic [DIGITS-1:0]     oAn,
    output logic                  oFrame
);

    localparam int unsigned CNT_W = ctrWidth(SCAN_DIV);
    localparam int unsigned IDX_W = ctrWidth(DIGITS);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

    if (DIGITS < 1 || DIGITS > 16) begin : gBadDigits
        $error("seg7_scan_driver: DIGITS must be in 1..16");
    end
    if (SCAN_DIV < 2) begin : gBadDiv
        $error("seg7_scan_driver: SCAN_DIV must be >= 2");
    end
    if (BLANK_CYCLES >= SCAN_DIV) begin : gBadBlank
        $error("seg7_scan_driver: BLANK_CYCLES must be < SCAN_DIV");
    end

    scanState_t           state;
    scanState_t           stateNext;

    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic                 slotWrap;
    logic                 frameEnd;
    logic                 takeSnap;

    logic [4*DIGITS-1:0]  snapData;
    logic [DIGITS-1:0]    snapDp;
    logic [DIGITS-1:0]    snapBlank;
    logic                 snapLzs;

    logic [DIGITS-1:0]    suppressed;
    logic [3:0]           curNibble;
    logic                 curDp;
    logic                 curBlank;
    logic                 curSupp;
    logic [DIGITS-1:0]    anSel;
    logic [6:0]           fontSeg;
    logic                 lit;

    assign slotWrap = (cnt == CNT_LAST);
    assign frameEnd = slotWrap && (idx == IDX_LAST);

    // Snapshot arming state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_UNPRIMED;
        end else begin
            state <= stateNext;
        end
    end

    // Arming next-state and snapshot request: once after reset, then at each frame end.
    always_comb begin
        stateNext = state;
        takeSnap  = 1'b0;
        case (state)
            ST_UNPRIMED: begin
                takeSnap  = 1'b1;
                stateNext = ST_RUNNING;
            end
            ST_RUNNING: begin
                takeSnap  = frameEnd;
            end
            default: begin
                stateNext = ST_UNPRIMED;
            end
        endcase
    end

    // Slot prescaler and digit index; keeps running while the display is disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (slotWrap) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Frame snapshot of all display inputs, loaded together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snapData  <= '0;
            snapDp    <= '0;
            snapBlank <= '0;
            snapLzs   <= 1'b0;
        end else if (takeSnap) begin
            snapData  <= iData;
            snapDp    <= iDp;
            snapBlank <= iBlank;
            snapLzs   <= iLzs;
        end
    end

    // Leading-zero suppression: a run of zero nibbles without dp, from the top digit down.
    // Digit 0 is excluded from the loop so it always stays eligible.
    always_comb begin
        logic run;
        suppressed = '0;
        run        = snapLzs;
        for (int unsigned k = DIGITS - 1; k >= 1; k--) begin
            run           = run && (snapData[4*k +: 4] == 4'h0) && !snapDp[k];
            suppressed[k] = run;
        end
    end

    // Select the current digit's snapshot fields and its one-hot-low anode pattern.
    always_comb begin
        curNibble = '0;
        curDp     = 1'b0;
        curBlank  = 1'b0;
        curSupp   = 1'b0;
        anSel     = '1;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                curNibble = snapData[4*k +: 4];
                curDp     = snapDp[k];
                curBlank  = snapBlank[k];
                curSupp   = suppressed[k];
                anSel[k]  = 1'b0;
            end
        end
    end

    seg7_hex_decoder uDecoder (
        .nibble   (curNibble),
        .segments (fontSeg)
    );

    assign lit = ena && (cnt >= CNT_BLANK) && !curBlank && !curSupp;

    // Registered pin drivers; dark pattern during dead time, blanking or disable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oAn    <= '1;
            oSeg   <= SEG_OFF;
            oDp    <= 1'b1;
            oFrame <= 1'b0;
        end else begin
            oFrame <= takeSnap;
            if (lit) begin
                oAn  <= anSel;
                oSeg <= ~fontSeg;
                oDp  <= ~curDp;
            end else begin
                oAn  <= '1;
                oSeg <= SEG_OFF;
                oDp  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (DIGITS=4, SCAN_DIV=4, BLANK_CYCLES=1).
module tb_seg7_scan_driver;

    localparam int unsigned DIGITS       = 4;
    localparam int unsigned SCAN_DIV     = 4;
    localparam int unsigned BLANK_CYCLES = 1;

    localparam logic [6:0] FONT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic [15:0] iData;
    logic [3:0]  iDp;
    logic [3:0]  iBlank;
    logic        iLzs;
    logic [6:0]  oSeg;
    logic        oDp;
    logic [3:0]  oAn;
    logic        oFrame;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       frame;
    } exp_t;

    exp_t expQ[$];
    int   nTests = 0;
    int   nFail  = 0;

    // Reference model state
    int unsigned mCnt, mIdx;
    bit          mPrimed;
    logic [15:0] mData;
    logic [3:0]  mDp, mBlank;
    logic        mLzs;

    seg7_scan_driver #(
        .DIGITS       (DIGITS),
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .ena    (ena),
        .iData  (iData),
        .iDp    (iDp),
        .iBlank (iBlank),
        .iLzs   (iLzs),
        .oSeg   (oSeg),
        .oDp    (oDp),
        .oAn    (oAn),
        .oFrame (oFrame)
    );

    always #5 clk = ~clk;

    task automatic modelReset();
        mCnt = 0; mIdx = 0; mPrimed = 0;
        mData = '0; mDp = '0; mBlank = '0; mLzs = 1'b0;
        expQ.delete();
    endtask

    // Predict the outputs the coming edge registers, advance the model, then clock.
    task automatic stepClk();
        exp_t       e;
        logic [3:0] supp;
        logic [3:0] nib;
        logic       lit;
        supp = '0;
        for (int k = 1; k < 4; k++)
            supp[k] = mLzs && ((mData >> (4*k)) == 16'h0) && ((mDp >> k) == 4'h0);
        nib  = mData[4*mIdx +: 4];
        lit  = ena && (mCnt >= BLANK_CYCLES) && !mBlank[mIdx] && !supp[mIdx];
        e.an    = lit ? ~(4'b0001 << mIdx) : 4'hF;
        e.seg   = lit ? ~FONT[nib] : 7'h7F;
        e.dp    = lit ? ~mDp[mIdx] : 1'b1;
        e.frame = !mPrimed || (mCnt == SCAN_DIV - 1 && mIdx == DIGITS - 1);
        if (e.frame) begin
            mData = iData; mDp = iDp; mBlank = iBlank; mLzs = iLzs;
        end
        mPrimed = 1;
        if (mCnt == SCAN_DIV - 1) begin
            mCnt = 0;
            mIdx = (mIdx + 1) % DIGITS;
        end else begin
            mCnt++;
        end
        expQ.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Clock until a frame pulse leaves the scan at digit 0, slot start; outputs discarded.
    task automatic alignFrame();
        exp_t e;
        bit   done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            stepClk();
            e = expQ.pop_front();
            if (e.frame && mCnt == 0 && mIdx == 0) done = 1;
        end
        nTests++;
        if (!done) begin
            nFail++;
            $display("FAIL align: no frame boundary within 40 cycles");
        end
    endtask

    task automatic test_reset();
        exp_t got, want;
        int   frames;
        rst = 1; ena = 0; iData = '0; iDp = '0; iBlank = '0; iLzs = 0;
        modelReset();
        repeat (3) begin
            @(posedge clk); #1;
            got = {oAn, oSeg, oDp, oFrame};
            nTests++;
            if (got !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
                nFail++;
                $display("FAIL reset_hold: got %h want %h", got, {4'hF, 7'h7F, 1'b1, 1'b0});
            end
        end
        rst = 0;
        frames = 0;
        for (int s = 0; s < 16; s++) begin
            stepClk();
            want = expQ.pop_front();
            got  = {oAn, oSeg, oDp, oFrame};
            nTests++;
            if (got !== want) begin
                nFail++;
                $display("FAIL reset_model s%0d: got %h want %h", s, got, want);
            end
            nTests++;
            if ({oAn, oSeg, oDp} !== {4'hF, 7'h7F, 1'b1}) begin
                nFail++;
                $display("FAIL reset_dark s%0d: got %h want %h", s, {oAn, oSeg, oDp}, {4'hF, 7'h7F, 1'b1});
            end
            if (s == 0) begin
                nTests++;
                if (oFrame !== 1'b1) begin
                    nFail++;
                    $display("FAIL reset_first_frame: got %b want 1", oFrame);
                end
            end
            if (s < 15) frames += int'(oFrame);
        end
        nTests++;
        if (frames != 1) begin
            nFail++;
            $display("FAIL reset_frame_count: got %0d want 1", frames);
        end
    endtask

    task automatic test_scan();
        exp_t       got, want;
        logic [3:0] anTab [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
        logic [6:0] segTab[4] = '{7'h0E, 7'h08, 7'h24, 7'h79};
        iData = 16'h12AF; ena = 1;
        alignFrame();
        for (int s = 0; s < 32; s++) begin
            stepClk();
            want = expQ.pop_front();
            got  = {oAn, oSeg, oDp, oFrame};
            nTests++;
            if (got !== want) begin
                nFail++;
                $display("FAIL scan_model s%0d: got %h want %h", s, got, want);
            end
            nTests++;
            if ((s % 4) == 0) begin
                if (oAn !== 4'hF || oSeg !== 7'h7F) begin
                    nFail++;
                    $display("FAIL scan_dead s%0d: got an=%h seg=%h want an=f seg=7f", s, oAn, oSeg);
                end
            end else if (oAn !== anTab[(s/4)%4] || oSeg !== segTab[(s/4)%4] || oDp !== 1'b1) begin
                nFail++;
                $display("FAIL scan_lit s%0d: got an=%h seg=%h dp=%b want an=%h seg=%h dp=1",
                         s, oAn, oSeg, oDp, anTab[(s/4)%4], segTab[(s/4)%4]);
            end
        end
    endtask

    task automatic test_midframe();
        exp_t got, want;
        iData = 16'h1111;
        alignFrame();
        for (int s = 0; s < 20; s++) begin
            if (s == 5) iData = 16'h2222;
            stepClk();
            want = expQ.pop_front();
            got  = {oAn, oSeg, oDp, oFrame};
            nTests++;
            if (got !== want) begin
                nFail++;
                $display("FAIL mid_model s%0d: got %h want %h", s, got, want);
            end
            if (s >= 4 && s < 16 && (s % 4) != 0) begin
                nTests++;
                if (oSeg !== 7'h79) begin
                    nFail++;
                    $display("FAIL mid_old_data s%0d: got seg=%h want 79", s, oSeg);
                end
            end
            if (s == 15) begin
                nTests++;
                if (oFrame !== 1'b1) begin
                    nFail++;
                    $display("FAIL mid_frame_pulse: got %b want 1", oFrame);
                end
            end
            if (s >= 17) begin
                nTests++;
                if (oSeg !== 7'h24 || oAn !== 4'hE) begin
                    nFail++;
                    $display("FAIL mid_new_data s%0d: got an=%h seg=%h want an=e seg=24", s, oAn, oSeg);
                end
            end
        end
    endtask

    task automatic test_lzs();
        exp_t got, want;
        // Three cases: plain suppression, dp stops suppression, all-zero value.
        for (int c = 0; c < 3; c++) begin
            iLzs  = 1;
            iData = (c == 2) ? 16'h0000 : 16'h0030;
            iDp   = (c == 1) ? 4'b0100 : 4'b0000;
            alignFrame();
            for (int s = 0; s < 16; s++) begin
                stepClk();
                want = expQ.pop_front();
                got  = {oAn, oSeg, oDp, oFrame};
                nTests++;
                if (got !== want) begin
                    nFail++;
                    $display("FAIL lzs_model c%0d s%0d: got %h want %h", c, s, got, want);
                end
                if ((s % 4) == 2) begin
                    nTests++;
                    case (s / 4)
                        0: if (oAn !== 4'hE || oSeg !== 7'h40) begin
                               nFail++;
                               $display("FAIL lzs_d0 c%0d: got an=%h seg=%h want an=e seg=40", c, oAn, oSeg);
                           end
                        1: if (c == 2 ? (oAn !== 4'hF) : (oAn !== 4'hD || oSeg !== 7'h30)) begin
                               nFail++;
                               $display("FAIL lzs_d1 c%0d: got an=%h seg=%h", c, oAn, oSeg);
                           end
                        2: if (c == 1 ? (oAn !== 4'hB || oSeg !== 7'h40 || oDp !== 1'b0) : (oAn !== 4'hF)) begin
                               nFail++;
                               $display("FAIL lzs_d2 c%0d: got an=%h seg=%h dp=%b", c, oAn, oSeg, oDp);
                           end
                        default: if (oAn !== 4'hF) begin
                               nFail++;
                               $display("FAIL lzs_d3 c%0d: got an=%h want f", c, oAn);
                           end
                    endcase
                end
            end
        end
        iLzs = 0; iDp = '0;
    endtask

    task automatic test_blank_ena();
        exp_t got, want;
        iData = 16'h12AF; iBlank = 4'b0010;
        alignFrame();
        for (int s = 0; s < 32; s++) begin
            if (s == 25) ena = 0;
            if (s == 29) ena = 1;
            stepClk();
            want = expQ.pop_front();
            got  = {oAn, oSeg, oDp, oFrame};
            nTests++;
            if (got !== want) begin
                nFail++;
                $display("FAIL blank_model s%0d: got %h want %h", s, got, want);
            end
            if (s < 16) begin
                nTests++;
                if (oAn[1] !== 1'b1) begin
                    nFail++;
                    $display("FAIL blank_d1 s%0d: got an=%h want bit1 high", s, oAn);
                end
            end
            if (s == 2 || s == 10) begin
                nTests++;
                if (oAn !== (s == 2 ? 4'hE : 4'hB)) begin
                    nFail++;
                    $display("FAIL blank_other s%0d: got an=%h", s, oAn);
                end
            end
            if (s == 25) begin
                nTests++;
                if (oAn !== 4'hF) begin
                    nFail++;
                    $display("FAIL ena_off: got an=%h want f", oAn);
                end
            end
            if (s == 29) begin
                nTests++;
                if (oAn !== 4'h7 || oSeg !== 7'h79) begin
                    nFail++;
                    $display("FAIL ena_phase: got an=%h seg=%h want an=7 seg=79", oAn, oSeg);
                end
            end
        end
        iBlank = '0;
    endtask

    task automatic test_reset_mid();
        exp_t got, want;
        iData = 16'h12AF;
        alignFrame();
        for (int s = 0; s < 10; s++) begin
            stepClk();
            void'(expQ.pop_front());
        end
        rst = 1;
        #2;
        got = {oAn, oSeg, oDp, oFrame};
        nTests++;
        if (got !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            nFail++;
            $display("FAIL rst_async: got %h want %h", got, {4'hF, 7'h7F, 1'b1, 1'b0});
        end
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        for (int s = 0; s < 16; s++) begin
            stepClk();
            want = expQ.pop_front();
            got  = {oAn, oSeg, oDp, oFrame};
            nTests++;
            if (got !== want) begin
                nFail++;
                $display("FAIL rst_model s%0d: got %h want %h", s, got, want);
            end
            if (s == 0) begin
                nTests++;
                if (oFrame !== 1'b1 || oAn !== 4'hF) begin
                    nFail++;
                    $display("FAIL rst_restart: got fr=%b an=%h want fr=1 an=f", oFrame, oAn);
                end
            end
            if (s == 1) begin
                nTests++;
                if (oAn !== 4'hE || oSeg !== 7'h0E) begin
                    nFail++;
                    $display("FAIL rst_digit0: got an=%h seg=%h want an=e seg=0e", oAn, oSeg);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_midframe();
        test_lzs();
        test_blank_ena();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
